// File: rtl/fan_tach_meter.sv
// Fan tachometer meter: synchronises and debounces the open-drain tach line, counts
// falling edges over a fixed gate window and reports a saturated count plus a stall flag.
module fan_tach_meter #(
    parameter int ADC_BITWIDTH   = 8,
    parameter int GATE_TICKS     = 1000000,
    parameter int DEBOUNCE_TICKS = 16,
    parameter int STALL_WINDOWS  = 4
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    clk_en_i,
    input  logic                    enable_i,
    input  logic                    tach_i,
    output logic [ADC_BITWIDTH-1:0] ADC_value_o,
    output logic                    dataValid_STRB_o,
    output logic                    stall_o,
    output logic                    tach_level_o
);

    localparam int GATE_W  = (GATE_TICKS > 1) ? $clog2(GATE_TICKS) : 1;
    localparam int DEB_W   = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
    localparam int STALL_W = $clog2(STALL_WINDOWS + 1);

    localparam logic [GATE_W-1:0]       GATE_LAST = GATE_W'(GATE_TICKS - 1);
    localparam logic [DEB_W-1:0]        DEB_LAST  = DEB_W'(DEBOUNCE_TICKS - 1);
    localparam logic [STALL_W-1:0]      STALL_MAX = STALL_W'(STALL_WINDOWS);
    localparam logic [ADC_BITWIDTH-1:0] CNT_MAX   = '1;

    logic                    sync1_q;
    logic                    sync2_q;
    logic                    level_q;
    logic                    level_d;
    logic [DEB_W-1:0]        deb_cnt_q;
    logic [DEB_W-1:0]        deb_cnt_d;
    logic [GATE_W-1:0]       gate_q;
    logic [GATE_W-1:0]       gate_d;
    logic [ADC_BITWIDTH-1:0] edge_q;
    logic [ADC_BITWIDTH-1:0] edge_d;
    logic [STALL_W-1:0]      stall_cnt_q;
    logic [STALL_W-1:0]      stall_cnt_d;
    logic                    stall_q;
    logic                    stall_d;
    logic [ADC_BITWIDTH-1:0] adc_q;
    logic [ADC_BITWIDTH-1:0] adc_d;
    logic                    strb_q;
    logic                    strb_d;

    logic                    fall;
    logic                    close;
    logic [ADC_BITWIDTH-1:0] closing_count;

    // The synchroniser runs every clk_i cycle so metastability settles regardless of clk_en_i.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= tach_i;
            sync2_q <= sync1_q;
        end
    end

    // A new level is accepted after DEBOUNCE_TICKS consecutive mismatching ticks.
    always_comb begin
        level_d   = level_q;
        deb_cnt_d = deb_cnt_q;
        fall      = 1'b0;
        if (clk_en_i) begin
            if (sync2_q == level_q) begin
                deb_cnt_d = '0;
            end else if (deb_cnt_q == DEB_LAST) begin
                level_d   = sync2_q;
                deb_cnt_d = '0;
                fall      = level_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
    end

    assign close         = enable_i && clk_en_i && (gate_q == GATE_LAST);
    assign closing_count = (fall && (edge_q != CNT_MAX)) ? edge_q + 1'b1 : edge_q;

    // A falling edge on the closing tick is folded into the closing window's count.
    always_comb begin
        gate_d      = gate_q;
        edge_d      = edge_q;
        stall_cnt_d = stall_cnt_q;
        stall_d     = stall_q;
        adc_d       = adc_q;
        strb_d      = 1'b0;
        if (!enable_i) begin
            gate_d      = '0;
            edge_d      = '0;
            stall_cnt_d = '0;
            stall_d     = 1'b0;
        end else if (clk_en_i) begin
            if (close) begin
                gate_d = '0;
                edge_d = '0;
                adc_d  = closing_count;
                strb_d = 1'b1;
                if (closing_count == '0) begin
                    stall_cnt_d = (stall_cnt_q == STALL_MAX) ? STALL_MAX : stall_cnt_q + 1'b1;
                    stall_d     = (stall_cnt_d == STALL_MAX);
                end else begin
                    stall_cnt_d = '0;
                    stall_d     = 1'b0;
                end
            end else begin
                gate_d = gate_q + 1'b1;
                edge_d = closing_count;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            level_q     <= 1'b1;
            deb_cnt_q   <= '0;
            gate_q      <= '0;
            edge_q      <= '0;
            stall_cnt_q <= '0;
            stall_q     <= 1'b0;
            adc_q       <= '0;
            strb_q      <= 1'b0;
        end else begin
            level_q     <= level_d;
            deb_cnt_q   <= deb_cnt_d;
            gate_q      <= gate_d;
            edge_q      <= edge_d;
            stall_cnt_q <= stall_cnt_d;
            stall_q     <= stall_d;
            adc_q       <= adc_d;
            strb_q      <= strb_d;
        end
    end

    assign ADC_value_o      = adc_q;
    assign dataValid_STRB_o = strb_q;
    assign stall_o          = stall_q;
    assign tach_level_o     = level_q;

endmodule

// File: tb/tb_fan_tach_meter.sv
// Directed bench for fan_tach_meter: one short-gate instance for window/stall/debounce
// behaviour and one long-gate instance for count saturation.
module tb_fan_tach_meter;

  logic       clk;
  logic       clk_en;
  logic       rstn;
  logic       enable_a;
  logic       enable_b;
  logic       tach_a;
  logic       tach_b;
  logic [7:0] adc_a;
  logic [7:0] adc_b;
  logic       strb_a;
  logic       strb_b;
  logic       stall_a;
  logic       stall_b;
  logic       level_a;
  logic       level_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int strb_cnt_a = 0;

  fan_tach_meter #(
    .ADC_BITWIDTH(8), .GATE_TICKS(100), .DEBOUNCE_TICKS(4), .STALL_WINDOWS(2)
  ) u_dut_a (
    .clk_i(clk), .rstn_i(rstn), .clk_en_i(clk_en), .enable_i(enable_a), .tach_i(tach_a),
    .ADC_value_o(adc_a), .dataValid_STRB_o(strb_a), .stall_o(stall_a), .tach_level_o(level_a)
  );

  fan_tach_meter #(
    .ADC_BITWIDTH(8), .GATE_TICKS(4000), .DEBOUNCE_TICKS(4), .STALL_WINDOWS(2)
  ) u_dut_b (
    .clk_i(clk), .rstn_i(rstn), .clk_en_i(clk_en), .enable_i(enable_b), .tach_i(tach_b),
    .ADC_value_o(adc_b), .dataValid_STRB_o(strb_b), .stall_o(stall_b), .tach_level_o(level_b)
  );

  // clock / reset infrastructure
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial clk_en = 1'b0;
  always @(negedge clk) clk_en = ~clk_en;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (strb_a) strb_cnt_a++;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

  // checking
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    while (!clk_en) @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic square_a(input int half, input int periods);
    for (int i = 0; i < periods; i++) begin
      tach_a = 1'b0;
      ticks(half);
      tach_a = 1'b1;
      ticks(half);
    end
  endtask

  task automatic wait_strobe(input bit sel, input int budget, output int at_cyc,
                             output logic [7:0] val, output logic st);
    bit got;
    int n;
    got = 1'b0;
    n = 0;
    at_cyc = 0;
    val = '0;
    st = 1'b0;
    while (!got && n < budget) begin
      @(negedge clk);
      n++;
      if (sel ? strb_b : strb_a) begin
        got = 1'b1;
        at_cyc = cyc;
        val = sel ? adc_b : adc_a;
        st = sel ? stall_b : stall_a;
      end
    end
    check("strobe_seen", {31'd0, got}, 32'd1);
  endtask

  // stimulus
  initial begin
    int t0;
    int tc;
    int n0;
    logic [7:0] v;
    logic s;
    bit low_seen;

    rstn = 1'b0;
    enable_a = 1'b0;
    enable_b = 1'b0;
    tach_a = 1'b1;
    tach_b = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_adc", adc_a, 0);
    check("rst_strb", strb_a, 0);
    check("rst_stall", stall_a, 0);
    check("rst_level", level_a, 1);
    rstn = 1'b1;
    repeat (4) @(negedge clk);

    // 1: idle high line, zero windows drive the stall flag
    tick();
    enable_a = 1'b1;
    t0 = cyc;
    wait_strobe(1'b0, 260, tc, v, s);
    check("t1_w1_val", v, 0);
    check("t1_w1_stall", s, 0);
    check("t1_w1_period", tc - t0, 200);
    @(negedge clk);
    check("t1_strobe_width", strb_a, 0);
    t0 = tc;
    wait_strobe(1'b0, 260, tc, v, s);
    check("t1_w2_val", v, 0);
    check("t1_w2_stall", s, 1);
    check("t1_w2_period", tc - t0, 200);
    t0 = tc;

    // 2: 20-tick square wave gives five pulses per window
    fork
      square_a(10, 20);
      begin
        for (int w = 0; w < 3; w++) begin
          wait_strobe(1'b0, 260, tc, v, s);
          check("t2_val", v, 5);
          check("t2_stall", s, 0);
          check("t2_period", tc - t0, 200);
          t0 = tc;
        end
      end
    join
    wait_strobe(1'b0, 260, tc, v, s);
    check("t2_last_val", v, 5);
    check("t2_last_period", tc - t0, 200);
    t0 = tc;

    // 3: two-tick glitches must be rejected
    low_seen = 1'b0;
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          tach_a = ((i % 10) < 2) ? 1'b0 : 1'b1;
          tick();
          if (!level_a) low_seen = 1'b1;
        end
      end
      wait_strobe(1'b0, 260, tc, v, s);
    join
    check("t3_level_low", {31'd0, low_seen}, 0);
    check("t3_val", v, 0);
    check("t3_stall", s, 0);
    check("t3_period", tc - t0, 200);

    // 5: falling edge accepted on the close tick belongs to the closing window
    fork
      begin
        square_a(6, 3);
        ticks(59);
        tach_a = 1'b0;
      end
      wait_strobe(1'b0, 260, tc, v, s);
    join
    check("t5_close_val", v, 4);
    check("t5_close_stall", s, 0);
    fork
      begin
        ticks(10);
        tach_a = 1'b1;
        ticks(10);
        square_a(5, 2);
      end
      wait_strobe(1'b0, 260, tc, v, s);
    join
    check("t5_next_val", v, 2);

    // 6: reset mid-window, then disabled period, then re-enable
    square_a(5, 3);
    #3;
    rstn = 1'b0;
    #1;
    check("t6_rst_adc", adc_a, 0);
    check("t6_rst_strb", strb_a, 0);
    check("t6_rst_stall", stall_a, 0);
    check("t6_rst_level", level_a, 1);
    enable_a = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    n0 = strb_cnt_a;
    square_a(5, 4);
    tach_a = 1'b0;
    ticks(6);
    check("t6_dis_level_low", level_a, 0);
    tach_a = 1'b1;
    ticks(6);
    check("t6_dis_level_high", level_a, 1);
    check("t6_dis_adc", adc_a, 0);
    check("t6_dis_stall", stall_a, 0);
    check("t6_dis_strobes", strb_cnt_a - n0, 0);
    tick();
    enable_a = 1'b1;
    t0 = cyc;
    fork
      square_a(10, 5);
      wait_strobe(1'b0, 260, tc, v, s);
    join
    check("t6_reen_val", v, 5);
    check("t6_reen_period", tc - t0, 200);
    check("t6_reen_stall", s, 0);
    enable_a = 1'b0;
    @(negedge clk);
    n0 = strb_cnt_a;
    square_a(5, 4);
    check("t6_hold_adc", adc_a, 5);
    check("t6_hold_stall", stall_a, 0);
    check("t6_hold_strobes", strb_cnt_a - n0, 0);

    // 4: debounce-limited toggling saturates the count at 255
    tick();
    enable_b = 1'b1;
    t0 = cyc;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          tach_b = 1'b0;
          ticks(4);
          tach_b = 1'b1;
          ticks(4);
        end
      end
      begin
        wait_strobe(1'b1, 8100, tc, v, s);
        check("t4_w1_val", v, 255);
        check("t4_w1_period", tc - t0, 8000);
        check("t4_w1_stall", s, 0);
        t0 = tc;
        wait_strobe(1'b1, 8100, tc, v, s);
        check("t4_w2_val", v, 255);
        check("t4_w2_period", tc - t0, 8000);
      end
    join

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fan_tach_meter.md
Name: fan_tach_meter

Overview:
Measures fan speed from the open-drain tachometer line and produces the 8-bit speed sample plus a one-cycle valid strobe. These feed the controller's ADC_value_i and dataVaild_STRB_i inputs directly upstream.
- Runs on the same 10 MHz clk_en_i tick as the controller.
- Counts debounced tach pulses over a fixed gate window.
- Flags a stalled fan.

Parameters:
- ADC_BITWIDTH, 8, width of the speed sample (pulse count per window, saturating).
- GATE_TICKS, 1000000, clk_en_i ticks per measurement window (100 ms at 10 MHz).
- DEBOUNCE_TICKS, 16, consecutive clk_en_i ticks a new tach level must hold before it is accepted.
- STALL_WINDOWS, 4, consecutive zero-count windows before stall_o asserts.

Ports:
- clk_i  in  1  system clock.
- rstn_i  in  1  reset; asynchronous, active-low.
- clk_en_i  in  1  10 MHz clock-enable tick.
- enable_i  in  1  measurement enable.
- tach_i  in  1  raw asynchronous tach line; idle high, pulled low per pulse.
- ADC_value_o  out  ADC_BITWIDTH  last completed window's pulse count, saturated.
- dataValid_STRB_o  out  1  one-clk_i-cycle strobe when ADC_value_o updates.
- stall_o  out  1  fan stalled.
- tach_level_o  out  1  debounced tach level (debug).

Behaviour:
- Reset is asynchronous on rstn_i low and applies to all flops. Reset values:
  - sync flops = 1, tach_level_o = 1
  - debounce counter = 0, gate counter = 0, edge counter = 0, stall counter = 0
  - ADC_value_o = 0, dataValid_STRB_o = 0, stall_o = 0
- Synchronizer: 2-FF synchronizer on tach_i, clocked every clk_i cycle (not gated by clk_en_i).
- Debounce: advances only on clk_en_i.
  - If the synchronized value equals tach_level_o, the debounce counter clears.
  - Otherwise the counter increments. When it reaches DEBOUNCE_TICKS-1 on a clk_en_i cycle, tach_level_o takes the synced value and the counter clears.
  - Minimum acceptance latency from a tach_i change: 2 clk_i cycles + DEBOUNCE_TICKS clk_en_i ticks.
- Pulse definition: one pulse = one falling edge of tach_level_o (1->0). Rising edges are ignored.
- Edge counter: ADC_BITWIDTH bits, saturating at 2^ADC_BITWIDTH-1, never wraps.
- Gate counter:
  - Counts 0..GATE_TICKS-1 on clk_en_i.
  - On the clk_en_i cycle where it equals GATE_TICKS-1 (window close), it returns to 0 and the next window starts immediately. There are no dead ticks.
- Window close, same clk_i cycle:
  - ADC_value_o <= saturate(edge counter + falling edge this cycle). A pulse coinciding with close belongs to the closing window.
  - Edge counter <= 0.
  - dataValid_STRB_o registers to 1 and is high for exactly the following clk_i cycle, aligned with the new ADC_value_o.
  - Strobe period is exactly GATE_TICKS clk_en_i ticks.
- Stall detection, evaluated at window close:
  - Closing count = 0: stall counter increments, saturating at STALL_WINDOWS.
  - Closing count > 0: stall counter clears and stall_o deasserts with the same update.
  - stall_o = (stall counter == STALL_WINDOWS), registered, and changes only at window close.
- enable_i low:
  - Gate, edge and stall counters are held at 0; no strobes; stall_o = 0.
  - ADC_value_o holds its last value.
  - Synchronizer and debounce keep running.
  - On enable_i rising, the first window starts at gate count 0. The first strobe comes after a full GATE_TICKS ticks.
- clk_en_i low: nothing advances except the synchronizer. The strobe flop still self-clears on the next clk_i cycle.
- Reset mid-window: the partial count is discarded and no strobe is issued.
- Arithmetic: the gate counter width is the smallest width holding GATE_TICKS-1. All compares are unsigned.

Test Plan:
Bench parameters: GATE_TICKS=100, DEBOUNCE_TICKS=4, STALL_WINDOWS=2, clk_en_i every 2nd clk_i cycle.
1. Reset then enable_i=1, tach_i held high for 100 ticks -> first strobe with ADC_value_o=0; stall_o stays 0 until the second zero window, then 1.
2. tach_i square wave with 10-tick low and 10-tick high phases -> every window reports ADC_value_o=5; strobes exactly 200 clk_i apart; stall_o clears at the first nonzero close.
3. 2-tick glitches low on tach_i -> no falling edge accepted; tach_level_o stays 1; ADC_value_o=0.
4. tach_i toggled every 4 ticks (debounce-limited) with GATE_TICKS=4000 -> count reaches 255 and holds 255 (no wrap).
5. Debounced falling edge forced onto the window-close tick -> counted in the closing window (value N+1); the next window starts at 0.
6. Negate rstn_i mid-window, then negate enable_i for 50 ticks -> outputs return to reset values immediately; no strobe while disabled; ADC_value_o held; first strobe 100 ticks after enable_i re-asserts.
